// File: rtl/trdb_trace_ctrl.sv
// trdb_trace_ctrl: trace session sequencer (wait ready, start, run with resync, stop, drain).
// Moore FSM; request outputs decode from the state register, resync request is registered.
module trdb_trace_ctrl #(
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned DRAIN_TIMEOUT = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             trace_activated_i,
    input  logic             trace_req_on_i,
    input  logic             trace_req_off_i,
    input  logic             encapsulator_ready_i,
    input  logic             start_ack_i,
    input  logic             stop_ack_i,
    input  logic             packet_emitted_i,
    input  logic             packet_pending_i,
    input  logic [CNT_W-1:0] resync_period_i,
    input  logic             resync_ack_i,
    output logic             trace_enable_o,
    output logic             start_req_o,
    output logic             stop_req_o,
    output logic             resync_req_o,
    output logic [2:0]       state_o,
    output logic             drain_timeout_o
);
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_READY = 3'd1,
        START      = 3'd2,
        RUN        = 3'd3,
        STOP       = 3'd4,
        DRAIN      = 3'd5
    } state_e;

    localparam int unsigned       DW         = DRAIN_TIMEOUT > 1 ? $clog2(DRAIN_TIMEOUT) : 1;
    localparam logic [DW-1:0]     DRAIN_LAST = DW'(DRAIN_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  ONE        = CNT_W'(1);

    state_e              state_q, state_d;
    logic                on_q, off_q, pending_off_q, resync_req_q, drain_timeout_q;
    logic [CNT_W-1:0]    resync_cnt_q;
    logic [DW-1:0]       drain_cnt_q;
    logic                on_edge, off_edge, resync_on, resync_hit, drain_expired;

    assign on_edge       = trace_req_on_i & ~on_q;
    assign off_edge      = trace_req_off_i & ~off_q;
    assign resync_on     = state_q == RUN && resync_period_i != '0;
    assign resync_hit    = resync_on && packet_emitted_i && resync_cnt_q == resync_period_i - ONE;
    assign drain_expired = state_q == DRAIN && packet_pending_i && drain_cnt_q == DRAIN_LAST;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (on_edge && trace_activated_i && !off_edge) state_d = WAIT_READY;
            WAIT_READY: state_d = (off_edge || !trace_activated_i) ? IDLE :
                                  encapsulator_ready_i ? START : WAIT_READY;
            START:      if (start_ack_i) state_d = RUN;
            RUN:        if (off_edge || pending_off_q || !trace_activated_i || !encapsulator_ready_i)
                            state_d = STOP;
            STOP:       if (stop_ack_i) state_d = DRAIN;
            DRAIN:      if (!packet_pending_i || drain_expired) state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= IDLE;
            on_q            <= 1'b0;
            off_q           <= 1'b0;
            pending_off_q   <= 1'b0;
            resync_req_q    <= 1'b0;
            drain_timeout_q <= 1'b0;
            resync_cnt_q    <= '0;
            drain_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            on_q          <= trace_req_on_i;
            off_q         <= trace_req_off_i;
            // an off request seen during START is only honoured once the start packet is out
            pending_off_q <= state_q == START && (pending_off_q || off_edge || !trace_activated_i);
            resync_req_q  <= state_q == RUN && state_d == RUN &&
                             (resync_hit || (resync_req_q && !resync_ack_i));
            if (state_q == START && start_ack_i)
                resync_cnt_q <= '0;
            else if (resync_hit)
                resync_cnt_q <= '0;
            else if (resync_on && packet_emitted_i && resync_cnt_q != '1)
                resync_cnt_q <= resync_cnt_q + ONE;
            drain_cnt_q <= state_q == DRAIN ? drain_cnt_q + DW'(1) : '0;
            if (state_q == START && start_ack_i)
                drain_timeout_q <= 1'b0;
            else if (drain_expired)
                drain_timeout_q <= 1'b1;
        end
    end

    assign trace_enable_o  = state_q inside {START, RUN, STOP};
    assign start_req_o     = state_q == START;
    assign stop_req_o      = state_q == STOP;
    assign resync_req_o    = resync_req_q;
    assign state_o         = state_q;
    assign drain_timeout_o = drain_timeout_q;
endmodule

// File: tb/tb_trdb_trace_ctrl.sv
// tb_trdb_trace_ctrl: directed session scenarios plus random traffic, checked each cycle
// against a session-level reference model.
module tb_trdb_trace_ctrl;
    localparam int DT = 64;

    logic        clk = 0;
    logic        rst, act, req_on, req_off, ready, start_ack, stop_ack, emitted, pending, rs_ack;
    logic [15:0] period;
    logic        en_o, start_o, stop_o, rs_o, tmo_o;
    logic [2:0]  state_o;

    int  checks = 0, failures = 0;
    bit  chk_en = 0;

    int  m_state, m_pkts, m_drain_at, mcyc;
    bit  m_prev_on, m_prev_off, m_rs, m_poff, m_tmo;

    trdb_trace_ctrl #(.CNT_W(16), .DRAIN_TIMEOUT(DT)) dut (
        .clk_i(clk), .rst_i(rst), .trace_activated_i(act), .trace_req_on_i(req_on),
        .trace_req_off_i(req_off), .encapsulator_ready_i(ready), .start_ack_i(start_ack),
        .stop_ack_i(stop_ack), .packet_emitted_i(emitted), .packet_pending_i(pending),
        .resync_period_i(period), .resync_ack_i(rs_ack), .trace_enable_o(en_o),
        .start_req_o(start_o), .stop_req_o(stop_o), .resync_req_o(rs_o),
        .state_o(state_o), .drain_timeout_o(tmo_o)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] v(bit en, bit st, bit sp, bit rs, bit to, int s);
        return {en, st, sp, rs, to, 3'(s)};
    endfunction

    function automatic logic [7:0] dut_vec();
        return {en_o, start_o, stop_o, rs_o, tmo_o, state_o};
    endfunction

    function automatic logic [7:0] mdl_vec();
        return v(m_state >= 2 && m_state <= 4, m_state == 2, m_state == 4, m_rs, m_tmo, m_state);
    endfunction

    // Session-level model: packets since last resync and drain entry time instead of counters.
    task automatic model_step();
        bit on_e, off_e, hit;
        int nxt;
        mcyc++;
        if (rst) begin
            m_state = 0; m_prev_on = 0; m_prev_off = 0; m_pkts = 0;
            m_rs = 0; m_poff = 0; m_tmo = 0;
            return;
        end
        on_e = req_on && !m_prev_on;
        off_e = req_off && !m_prev_off;
        m_prev_on = req_on;
        m_prev_off = req_off;
        nxt = m_state;
        hit = 0;
        if (m_state == 0) begin
            if (on_e && act && !off_e) nxt = 1;
        end else if (m_state == 1) begin
            if (off_e || !act) nxt = 0;
            else if (ready) nxt = 2;
        end else if (m_state == 2) begin
            if (off_e || !act) m_poff = 1;
            if (start_ack) begin nxt = 3; m_pkts = 0; m_tmo = 0; end
        end else if (m_state == 3) begin
            if (off_e || m_poff || !act || !ready) nxt = 4;
            if (period != 0 && emitted) begin
                if (m_pkts == int'(period) - 1) begin hit = 1; m_pkts = 0; end
                else m_pkts++;
            end
        end else if (m_state == 4) begin
            if (stop_ack) begin nxt = 5; m_drain_at = mcyc; end
        end else begin
            if (!pending) nxt = 0;
            else if (mcyc - m_drain_at == DT) begin nxt = 0; m_tmo = 1; end
        end
        m_rs = m_state == 3 && nxt == 3 && (hit || (m_rs && !rs_ack));
        if (nxt != 2 && nxt != 3) m_poff = 0;
        m_state = nxt;
    endtask

    task automatic cyc(int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
        end
    endtask

    task automatic pin(string name, logic [7:0] lit);
        checks++;
        if (dut_vec() !== lit) begin
            failures++;
            $display("FAIL %s: dut=%b expected=%b", name, dut_vec(), lit);
        end
        checks++;
        if (mdl_vec() !== lit) begin
            failures++;
            $display("FAIL %s_model: model=%b expected=%b", name, mdl_vec(), lit);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                failures++;
                $display("FAIL cycle_cmp t=%0t dut=%b model=%b", $time, dut_vec(), mdl_vec());
            end
        end
    end

    task automatic reopen();
        req_on = 0; req_off = 0;
        cyc(1);
        req_on = 1;
        cyc(2);
    endtask

    initial begin
        mcyc = 0; m_drain_at = 0;
        rst = 1; act = 1; req_on = 1; req_off = 0; ready = 1; start_ack = 0; stop_ack = 0;
        emitted = 0; pending = 0; rs_ack = 0; period = 0;
        cyc(1);
        chk_en = 1;
        cyc(1);
        pin("reset", v(0,0,0,0,0,0));
        rst = 0;
        // 1: bring-up with req_on already high at reset release
        cyc(1); pin("t1_wait", v(0,0,0,0,0,1));
        cyc(1); pin("t1_start", v(1,1,0,0,0,2));
        cyc(1); pin("t1_start_hold", v(1,1,0,0,0,2));
        start_ack = 1; cyc(1); start_ack = 0;
        pin("t1_run", v(1,0,0,0,0,3));
        // 2: resync every 4 packets, then disabled
        period = 4;
        for (int i = 0; i < 4; i++) begin
            emitted = 1; cyc(1); emitted = 0;
            pin("t2_pulse", v(1,0,0,i == 3,0,3));
            cyc(1);
        end
        cyc(3); pin("t2_held", v(1,0,0,1,0,3));
        rs_ack = 1; cyc(1); rs_ack = 0;
        pin("t2_acked", v(1,0,0,0,0,3));
        period = 0;
        for (int i = 0; i < 10; i++) begin
            emitted = 1; cyc(1); emitted = 0; cyc(1);
        end
        pin("t2_period0", v(1,0,0,0,0,3));
        // 3: stop and short drain
        req_off = 1; cyc(1); pin("t3_stop", v(1,0,1,0,0,4));
        stop_ack = 1; pending = 1; cyc(1); stop_ack = 0;
        pin("t3_drain", v(0,0,0,0,0,5));
        cyc(4); pin("t3_drain_hold", v(0,0,0,0,0,5));
        pending = 0; cyc(1); pin("t3_idle", v(0,0,0,0,0,0));
        // 4: drain timeout
        reopen(); pin("t4_start", v(1,1,0,0,0,2));
        start_ack = 1; cyc(1); start_ack = 0;
        req_off = 1; cyc(1); pin("t4_stop", v(1,0,1,0,0,4));
        stop_ack = 1; pending = 1; cyc(1); stop_ack = 0;
        cyc(DT - 1); pin("t4_drain_last", v(0,0,0,0,0,5));
        cyc(1); pin("t4_timeout", v(0,0,0,0,1,0));
        reopen(); pin("t4_sticky", v(1,1,0,0,1,2));
        start_ack = 1; cyc(1); start_ack = 0;
        pin("t4_cleared", v(1,0,0,0,0,3));
        // 5: off during START, simultaneous edges in IDLE
        req_off = 1; cyc(1);
        stop_ack = 1; pending = 0; cyc(1); stop_ack = 0;
        cyc(1); pin("t5_idle", v(0,0,0,0,0,0));
        reopen();
        req_off = 1; cyc(1); pin("t5_start_off", v(1,1,0,0,0,2));
        cyc(1); pin("t5_start_wait", v(1,1,0,0,0,2));
        start_ack = 1; cyc(1); start_ack = 0;
        pin("t5_run_once", v(1,0,0,0,0,3));
        cyc(1); pin("t5_stop", v(1,0,1,0,0,4));
        stop_ack = 1; cyc(1); stop_ack = 0; cyc(1);
        req_on = 0; req_off = 0; cyc(1);
        req_on = 1; req_off = 1; cyc(1); pin("t5_both", v(0,0,0,0,0,0));
        cyc(1); pin("t5_both_hold", v(0,0,0,0,0,0));
        // 6: reset mid-run, ready loss in RUN
        reopen(); start_ack = 1; cyc(1); start_ack = 0;
        period = 1; emitted = 1; cyc(1); emitted = 0;
        pin("t6_resync", v(1,0,0,1,0,3));
        rst = 1; cyc(1); rst = 0;
        pin("t6_reset", v(0,0,0,0,0,0));
        cyc(1); pin("t6_rewait", v(0,0,0,0,0,1));
        cyc(1); start_ack = 1; cyc(1); start_ack = 0;
        ready = 0; cyc(1); pin("t6_not_ready", v(1,0,1,0,0,4));
        ready = 1;
        // random traffic against the model
        for (int i = 0; i < 6000; i++) begin
            rst       = $urandom_range(699) == 0;
            act       = $urandom_range(39) != 0;
            ready     = $urandom_range(49) != 0;
            if ($urandom_range(7) == 0) req_on = ~req_on;
            if ($urandom_range(29) == 0) req_off = ~req_off;
            if ($urandom_range(59) == 0) pending = ~pending;
            if ($urandom_range(99) == 0) period = 16'($urandom_range(5));
            start_ack = $urandom_range(3) == 0;
            stop_ack  = $urandom_range(3) == 0;
            emitted   = $urandom_range(1) == 0;
            rs_ack    = $urandom_range(4) == 0;
            cyc(1);
        end
        rst = 0;
        cyc(2);
        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
